u_lsu: RTL and testbench

Load/store unit sitting directly downstream of the execute stage in the RV32I core. It accepts one load or store per transaction from execute, checks alignment, and drives a single-outstanding data-memory bus with a req/gnt/rvalid handshake. It formats byte lanes and write data, then sign- or zero-extends load data and returns it as a one-cycle register-file write. Misaligned accesses, bus errors and response timeouts are reported as one-cycle exception pulses.

---
 rtl/u_lsu.sv | 170 +++++++++++++++++
 tb/tb_u_lsu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/u_lsu.sv
// Load/store unit: alignment check, single-outstanding req/gnt/rvalid data bus,
// byte-lane formatting, load extension and one-cycle writeback/exception pulses.
module u_lsu #(
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_ld,
    input  logic        ex_st,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd_a,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    input  logic        dm_err,
    output logic        wb_e,
    output logic [4:0]  wb_a,
    output logic [31:0] wb_d,
    output logic        exc_misalign,
    output logic        exc_fault,
    output logic [31:0] exc_addr
);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t      state, state_nx;
    logic        op_ld;
    logic [2:0]  op_f3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [4:0]  op_rd;
    logic [7:0]  tmo_cnt;

    logic        accept;
    logic        illegal;
    logic        misalign;
    logic        tmo_hit;
    logic        in_req;
    logic [31:0] rd_shift;
    logic [31:0] ld_data;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid & ex_ready & (ex_ld | ex_st);

    // Loads take priority when both ld and st are asserted.
    assign illegal  = ex_ld ? ((ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11))
                            : (ex_funct3[2] || (ex_funct3[1:0] == 2'b11));
    assign misalign = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                      ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));

    assign tmo_hit  = (tmo_cnt == 8'(RSP_TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && !illegal && !misalign) state_nx = REQ;
            REQ:  if (dm_gnt) state_nx = RSP;
            RSP:  if (dm_rvalid || tmo_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_shift = dm_rdata >> {op_addr[1:0], 3'b000};
        case (op_f3)
            3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_data = {24'd0, rd_shift[7:0]};
            3'b101:  ld_data = {16'd0, rd_shift[15:0]};
            default: ld_data = rd_shift;
        endcase
    end

    // Bus outputs are a pure function of state and latched op, so reset drops them at once.
    assign in_req   = (state == REQ);
    assign dm_req   = in_req;
    assign dm_we    = in_req & ~op_ld;
    assign dm_addr  = in_req ? {op_addr[31:2], 2'b00} : '0;

    always_comb begin
        dm_be    = '0;
        dm_wdata = '0;
        if (in_req) begin
            case (op_f3[1:0])
                2'b00:   dm_be = 4'b0001 << op_addr[1:0];
                2'b01:   dm_be = 4'b0011 << op_addr[1:0];
                default: dm_be = 4'b1111;
            endcase
            if (!op_ld) begin
                case (op_f3[1:0])
                    2'b00:   dm_wdata = {4{op_wdata[7:0]}};
                    2'b01:   dm_wdata = {2{op_wdata[15:0]}};
                    default: dm_wdata = op_wdata;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            op_ld        <= 1'b0;
            op_f3        <= '0;
            op_addr      <= '0;
            op_wdata     <= '0;
            op_rd        <= '0;
            tmo_cnt      <= '0;
            wb_e         <= 1'b0;
            wb_a         <= '0;
            wb_d         <= '0;
            exc_misalign <= 1'b0;
            exc_fault    <= 1'b0;
            exc_addr     <= '0;
        end else begin
            state        <= state_nx;
            wb_e         <= 1'b0;
            exc_misalign <= 1'b0;
            exc_fault    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_ld    <= ex_ld;
                        op_f3    <= ex_funct3;
                        op_addr  <= ex_addr;
                        op_wdata <= ex_wdata;
                        op_rd    <= ex_rd_a;
                        if (illegal) begin
                            exc_fault <= 1'b1;
                            exc_addr  <= ex_addr;
                        end else if (misalign) begin
                            exc_misalign <= 1'b1;
                            exc_addr     <= ex_addr;
                        end
                    end
                end
                REQ: begin
                    if (dm_gnt) tmo_cnt <= '0;
                end
                RSP: begin
                    if (dm_rvalid) begin
                        if (dm_err) begin
                            exc_fault <= 1'b1;
                            exc_addr  <= op_addr;
                        end else if (op_ld) begin
                            wb_e <= (op_rd != 5'd0);
                            wb_a <= op_rd;
                            wb_d <= ld_data;
                        end
                    end else if (tmo_hit) begin
                        exc_fault <= 1'b1;
                        exc_addr  <= op_addr;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_u_lsu.sv
// Self-checking bench for u_lsu: transaction-level reference model with
// directed cases from the test plan followed by randomized traffic.
module tb_u_lsu;

    localparam int unsigned TMO = 12;

    logic        clk;
    logic        rstn;
    logic        ex_valid, ex_ready, ex_ld, ex_st;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd_a;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_gnt, dm_rvalid, dm_err;
    logic [31:0] dm_rdata;
    logic        wb_e;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    logic        exc_misalign, exc_fault;
    logic [31:0] exc_addr;

    u_lsu #(.RSP_TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ld(ex_ld), .ex_st(ex_st),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd_a(ex_rd_a),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d),
        .exc_misalign(exc_misalign), .exc_fault(exc_fault), .exc_addr(exc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic run_chk = 1'b0;

    // Expectations for the current cycle, and pulses scheduled for the next one.
    logic        exp_ready = 1'b1, exp_req = 1'b0, exp_we = 1'b0;
    logic [31:0] exp_addr = '0, exp_wd = '0;
    logic [3:0]  exp_be = '0;
    logic        exp_wb_e = 1'b0, exp_mis = 1'b0, exp_flt = 1'b0;
    logic [4:0]  exp_wb_a = '0;
    logic [31:0] exp_wb_d = '0, exp_eaddr = '0;
    logic        nx_wb_e = 1'b0, nx_mis = 1'b0, nx_flt = 1'b0;
    logic [4:0]  nx_wb_a = '0;
    logic [31:0] nx_wb_d = '0, nx_eaddr = '0;

    logic [31:0] last_wb_d = '0, last_eaddr = '0, last_addr = '0, last_wd = '0;
    logic [3:0]  last_be = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && run_chk) begin
            check("ex_ready", 32'(ex_ready), 32'(exp_ready));
            check("dm_req", 32'(dm_req), 32'(exp_req));
            if (exp_req) begin
                check("dm_addr", dm_addr, exp_addr);
                check("dm_be", 32'(dm_be), 32'(exp_be));
                check("dm_we", 32'(dm_we), 32'(exp_we));
                if (exp_we) check("dm_wdata", dm_wdata, exp_wd);
                last_addr = dm_addr; last_be = dm_be; last_wd = dm_wdata;
            end
            check("wb_e", 32'(wb_e), 32'(exp_wb_e));
            if (exp_wb_e) begin
                check("wb_a", 32'(wb_a), 32'(exp_wb_a));
                check("wb_d", wb_d, exp_wb_d);
            end
            if (wb_e) last_wb_d = wb_d;
            check("exc_misalign", 32'(exc_misalign), 32'(exp_mis));
            check("exc_fault", 32'(exc_fault), 32'(exp_flt));
            if (exp_mis || exp_flt) check("exc_addr", exc_addr, exp_eaddr);
            if (exc_misalign || exc_fault) last_eaddr = exc_addr;
        end
    end

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        int unsigned b[4];
        int unsigned k;
        int v;
        for (int i = 0; i < 4; i++) b[i] = (rdata / (32'd1 << (8 * i))) % 256;
        k = a % 4;
        case (f3)
            3'd0: begin v = int'(b[k]); if (v >= 128) v -= 256; return 32'(v); end
            3'd4: return 32'(b[k]);
            3'd1: begin v = int'(b[k] + 256 * b[k+1]); if (v >= 32768) v -= 65536; return 32'(v); end
            3'd5: return 32'(b[k] + 256 * b[k+1]);
            default: return rdata;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk); #1;
        exp_wb_e = nx_wb_e; exp_mis = nx_mis; exp_flt = nx_flt;
        if (nx_wb_e) begin exp_wb_a = nx_wb_a; exp_wb_d = nx_wb_d; end
        if (nx_mis || nx_flt) exp_eaddr = nx_eaddr;
        nx_wb_e = 1'b0; nx_mis = 1'b0; nx_flt = 1'b0;
        exp_ready = 1'b1; exp_req = 1'b0;
        ex_valid = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_err = 1'b0;
    endtask

    // Starts in an idle cycle; returns in the cycle carrying the result pulse.
    task automatic do_txn(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] w, input logic [4:0] rd,
                          input int unsigned gd, input int unsigned rdly,
                          input logic err, input logic [31:0] rdata);
        bit ill, mis;
        int unsigned sz;
        ex_valid = 1'b1; ex_ld = ld; ex_st = st; ex_funct3 = f3;
        ex_addr = a; ex_wdata = w; ex_rd_a = rd;
        if (!(ld || st)) begin tick(); return; end
        ill = ld ? !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : !(f3 inside {3'd0, 3'd1, 3'd2});
        sz  = int'(f3 % 4);
        mis = !ill && ((sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0));
        if (ill || mis) begin
            nx_flt = ill; nx_mis = mis; nx_eaddr = a;
            tick();
            return;
        end
        tick();
        for (int unsigned g = 0; ; g++) begin
            exp_ready = 1'b0; exp_req = 1'b1; exp_we = !ld;
            exp_addr = a - (a % 4);
            exp_be = (sz == 0) ? 4'(1 << (a % 4)) : (sz == 1) ? 4'(3 << (a % 4)) : 4'hF;
            exp_wd = (sz == 0) ? w[7:0] * 32'h0101_0101 : (sz == 1) ? w[15:0] * 32'h0001_0001 : w;
            dm_gnt = (g == gd);
            dm_rvalid = 1'($urandom % 2); dm_err = 1'($urandom % 2);
            ex_valid = 1'($urandom % 2); ex_ld = 1'($urandom % 2);
            tick();
            if (g == gd) break;
        end
        for (int unsigned r = 0; ; r++) begin
            exp_ready = 1'b0;
            dm_gnt = 1'($urandom % 2);
            ex_valid = 1'($urandom % 2); ex_st = 1'($urandom % 2);
            if (r == rdly) begin
                dm_rvalid = 1'b1; dm_rdata = rdata; dm_err = err;
                if (err) begin
                    nx_flt = 1'b1; nx_eaddr = a;
                end else if (ld) begin
                    nx_wb_e = (rd != 0); nx_wb_a = rd; nx_wb_d = model_load(f3, a, rdata);
                end
                tick();
                break;
            end
            dm_rvalid = 1'b0; dm_rdata = $urandom; dm_err = 1'($urandom % 2);
            if (r == TMO - 1) begin
                nx_flt = 1'b1; nx_eaddr = a;
                tick();
                break;
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; ex_valid = 1'b0; ex_ld = 1'b0; ex_st = 1'b0; ex_funct3 = '0;
        ex_addr = '0; ex_wdata = '0; ex_rd_a = '0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0; dm_err = 1'b0;
        #2;
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_dm_req", 32'(dm_req), 32'd0);
        check("rst_dm_be", 32'(dm_be), 32'd0);
        check("rst_dm_addr", dm_addr, 32'd0);
        check("rst_wb_e", 32'(wb_e), 32'd0);
        check("rst_wb_d", wb_d, 32'd0);
        check("rst_exc", 32'({exc_misalign, exc_fault}), 32'd0);
        check("rst_exc_addr", exc_addr, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rstn = 1'b1;
        run_chk = 1'b1;
        tick();

        do_txn(1, 0, 3'd2, 32'h100, 32'h0, 5'd5, 0, 0, 0, 32'hDEAD_BEEF); tick();
        check("pin_lw_be", 32'(last_be), 32'hF);
        check("pin_lw", last_wb_d, 32'hDEAD_BEEF);
        do_txn(1, 0, 3'd0, 32'h103, 32'h0, 5'd6, 0, 0, 0, 32'h8011_2233); tick();
        check("pin_lb", last_wb_d, 32'hFFFF_FF80);
        do_txn(1, 0, 3'd4, 32'h103, 32'h0, 5'd7, 1, 2, 0, 32'h8011_2233); tick();
        check("pin_lbu", last_wb_d, 32'h0000_0080);
        do_txn(1, 0, 3'd1, 32'h102, 32'h0, 5'd8, 0, 0, 0, 32'h8011_2233); tick();
        check("pin_lh", last_wb_d, 32'hFFFF_8011);
        do_txn(0, 1, 3'd1, 32'h202, 32'h0000_ABCD, 5'd9, 0, 1, 0, 32'h0);
        check("pin_sh_addr", last_addr, 32'h200);
        check("pin_sh_be", 32'(last_be), 32'hC);
        check("pin_sh_wdata", last_wd, 32'hABCD_ABCD);
        do_txn(1, 0, 3'd2, 32'h101, 32'h0, 5'd5, 0, 0, 0, 32'h0); tick();
        check("pin_misalign_addr", last_eaddr, 32'h101);

        do_txn(1, 0, 3'd2, 32'h300, 32'h0, 5'd3, 3, TMO + 5, 0, 32'h0);
        dm_rvalid = 1'b1; dm_rdata = 32'h1234_5678;
        tick();
        check("pin_timeout_addr", last_eaddr, 32'h300);
        do_txn(1, 0, 3'd2, 32'h400, 32'h0, 5'd0, 0, 1, 1, 32'h5555_5555); tick();
        do_txn(1, 0, 3'd3, 32'h500, 32'h0, 5'd1, 0, 0, 0, 32'h0);
        do_txn(0, 1, 3'd4, 32'h504, 32'h0, 5'd1, 0, 0, 0, 32'h0); tick();

        // Reset asserted while waiting for the response.
        ex_valid = 1'b1; ex_ld = 1'b1; ex_st = 1'b0; ex_funct3 = 3'd2; ex_addr = 32'h600; ex_rd_a = 5'd4;
        tick();
        exp_ready = 1'b0; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h600; exp_be = 4'hF;
        dm_gnt = 1'b1;
        tick();
        exp_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("rstmid_dm_req", 32'(dm_req), 32'd0);
        check("rstmid_ex_ready", 32'(ex_ready), 32'd1);
        dm_rvalid = 1'b1; dm_rdata = 32'hAAAA_AAAA;
        @(posedge clk);
        @(negedge clk); #1 rstn = 1'b1;
        tick();
        do_txn(1, 0, 3'd2, 32'h700, 32'h0, 5'd11, 0, 0, 0, 32'hCAFE_F00D); tick();
        check("pin_after_reset", last_wb_d, 32'hCAFE_F00D);

        for (int n = 0; n < 300; n++) begin
            logic ld, st;
            int unsigned kind, rdly;
            kind = $urandom % 16;
            ld = (kind < 8) || (kind == 15);
            st = (kind >= 8) && (kind != 14);
            rdly = ($urandom % 8 == 0) ? TMO + $urandom % 3 : $urandom % 4;
            do_txn(ld, st, 3'($urandom), $urandom, $urandom, 5'($urandom), $urandom % 4, rdly,
                   ($urandom % 8 == 0), $urandom);
        end
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
